// File: rtl/multdiv_pkg.sv
// Shared multiply/divide definitions: FSM states, Booth step selection, default width.
package multdiv_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_ADD  = 2'd1,
    SEL_SUB  = 2'd2
  } booth_sel_e;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_-1}.
  function automatic booth_sel_e booth_select(input logic q0, input logic q_m1);
    booth_sel_e sel;
    case ({q0, q_m1})
      2'b01:   sel = SEL_ADD;
      2'b10:   sel = SEL_SUB;
      default: sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// WIDTH+1-bit adder with carry-in: 8-bit carry-lookahead groups chained by group
// generate/propagate, plus a single ripple stage for the extra top bit.
module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           carry_in,
  output logic [WIDTH:0] sum
);

  localparam int GROUPS = WIDTH / 8;

  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;

  // Group carries come only from group G/P so no group depends on another's internals.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = carry_in;
    for (int j = 0; j < GROUPS; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
  end

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] c;

    assign p = a[gi*8 +: 8] ^ b[gi*8 +: 8];
    assign g = a[gi*8 +: 8] & b[gi*8 +: 8];

    // Each carry is a flat sum-of-products over g/p and the group carry-in.
    always_comb begin
      logic term;
      logic any;
      c = '0;
      for (int i = 0; i < 8; i++) begin
        any  = grp_c[gi];
        for (int k = 0; k < i; k++) any = any & p[k];
        for (int j = 0; j < i; j++) begin
          term = g[j];
          for (int k = j + 1; k < i; k++) term = term & p[k];
          any = any | term;
        end
        c[i] = any;
      end
    end

    always_comb begin
      logic gg;
      logic term;
      gg = 1'b0;
      for (int j = 0; j < 8; j++) begin
        term = g[j];
        for (int k = j + 1; k < 8; k++) term = term & p[k];
        gg = gg | term;
      end
      grp_g[gi] = gg;
    end

    assign grp_p[gi]        = &p;
    assign sum[gi*8 +: 8]   = p ^ c;
  end

  assign sum[WIDTH] = a[WIDTH] ^ b[WIDTH] ^ grp_c[GROUPS];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier, one step per clock.
// Optional overflow flag built only when MULT_EXCEPTION_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for ctrl_MULT
// RUN     | one Booth step per cycle, WIDTH steps total
// DONE    | publish result/exception, pulse data_resultRDY
module booth_multiplier
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_e      state;
  booth_sel_e       sel;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic             carry_in;
  logic [CNT_W-1:0] count;

  always_comb begin
    sel      = booth_select(q[0], q_m1);
    addend   = '0;
    carry_in = 1'b0;
    case (sel)
      SEL_ADD: addend = m;
      SEL_SUB: begin
        addend   = ~m;
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  cla_adder #(.WIDTH(WIDTH)) u_acc_adder (
    .a        (acc),
    .b        (addend),
    .carry_in (carry_in),
    .sum      (sum)
  );

  // A strobe is accepted in every state; in DONE the result is still published first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      m              <= '0;
      acc            <= '0;
      q              <= '0;
      q_m1           <= 1'b0;
      count          <= '0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == ST_DONE) begin
        data_result    <= q;
        data_resultRDY <= 1'b1;
      end
      if (ctrl_MULT) begin
        m     <= {data_operandA[WIDTH-1], data_operandA};
        acc   <= '0;
        q     <= data_operandB;
        q_m1  <= 1'b0;
        count <= '0;
        state <= ST_RUN;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            acc   <= {sum[WIDTH], sum[WIDTH:1]};
            q     <= {sum[0], q[WIDTH-1:1]};
            q_m1  <= q[0];
            count <= count + CNT_W'(1);
            if (count == LAST_STEP) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MULT_EXCEPTION_EN
  logic [WIDTH:0] upper;
  logic           overflow;

  assign upper    = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign overflow = ~((&upper) | ~(|upper));

  always_ff @(posedge clock) begin
    if (reset) begin
      data_exception <= 1'b0;
    end else if (state == ST_DONE) begin
      data_exception <= overflow;
    end
  end
`else
  assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases plus random operands
// against an arithmetic product model.
module tb_booth_multiplier;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  booth_multiplier #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full signed product, low half as result, overflow if it does not fit 32 bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
`ifdef MULT_EXCEPTION_EN
    e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
`else
    e = 1'b0;
`endif
  endtask

  // Called at a negedge; returns at the first negedge after the strobe edge.
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input int start, output int lat);
    lat = start;
    while (data_resultRDY !== 1'b1 && lat < 80) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic        ee;
    logic [31:0] prev;
    logic        prev_e;
    int          lat;
    model(a, b, er, ee);
    prev   = data_result;
    prev_e = data_exception;
    pulse(a, b);
    check({tag, " busy"}, 64'(busy), 64'(1'b1));
    check({tag, " hold_result"}, 64'(data_result), 64'(prev));
    check({tag, " hold_exc"}, 64'(data_exception), 64'(prev_e));
    wait_rdy(1, lat);
    check({tag, " latency"}, 64'(lat), 64'(34));
    check({tag, " result"}, 64'(data_result), 64'(er));
    check({tag, " exception"}, 64'(data_exception), 64'(ee));
    @(negedge clock);
    check({tag, " rdy_one_cycle"}, 64'(data_resultRDY), 64'(1'b0));
    check({tag, " result_kept"}, 64'(data_result), 64'(er));
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          pulses;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset result", 64'(data_result), 64'(0));
    check("reset exception", 64'(data_exception), 64'(0));
    check("reset rdy", 64'(data_resultRDY), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    run_op(32'd3, 32'd4, "3x4");
    run_op(-32'sd7, 32'd6, "-7x6");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "minxneg1");
    run_op(32'h0001_0000, 32'h0001_0000, "2^16x2^16");
    run_op(32'h8000_0000, 32'd1, "minx1");
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxxmax");
    run_op(32'h8000_0000, 32'h8000_0000, "minxmin");
    run_op(32'd0, 32'hDEAD_BEEF, "0xval");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "neg1xneg1");

    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) a = $signed(a) >>> 20;
      if (i % 3 == 2) b = $signed(b) >>> 18;
      run_op(a, b, $sformatf("rand%0d", i));
    end

    // Restart during RUN: only the second operation may complete.
    pulse(32'd5, 32'd5);
    pulses = 0;
    repeat (9) begin
      if (data_resultRDY === 1'b1) pulses++;
      @(negedge clock);
    end
    check("abort no_rdy_before_restart", 64'(pulses), 64'(0));
    run_op(32'd2, 32'd3, "abort_restart");

    // Reset mid-RUN discards the operation.
    pulse(32'd9, 32'd9);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset result", 64'(data_result), 64'(0));
    check("midreset exception", 64'(data_exception), 64'(0));
    check("midreset rdy", 64'(data_resultRDY), 64'(0));
    check("midreset busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) pulses++;
    end
    check("midreset no_rdy", 64'(pulses), 64'(0));
    run_op(32'd9, 32'd9, "after_reset");

    // Strobe while in DONE: first result still published, second op starts.
    pulse(32'h0000_1234, 32'h0000_0010);
    repeat (32) @(negedge clock);
    check("done_accept rdy_early", 64'(data_resultRDY), 64'(0));
    pulse(32'd7, -32'sd3);
    model(32'h0000_1234, 32'h0000_0010, er, ee);
    check("done_accept first_rdy", 64'(data_resultRDY), 64'(1'b1));
    check("done_accept first_result", 64'(data_result), 64'(er));
    check("done_accept busy", 64'(busy), 64'(1'b1));
    @(negedge clock);
    wait_rdy(2, lat);
    model(32'd7, -32'sd3, er, ee);
    check("done_accept latency", 64'(lat), 64'(34));
    check("done_accept second_result", 64'(data_result), 64'(er));
    check("done_accept second_exc", 64'(data_exception), 64'(ee));
    @(negedge clock);
    check("done_accept idle", 64'(busy), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the signed operand and result width; WIDTH is a multiple of 8.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port data_operandA, input, WIDTH bits: signed multiplicand, sampled only on an accepted start.
REQ-005 SHALL have port data_operandB, input, WIDTH bits: signed multiplier, sampled only on an accepted start.
REQ-006 SHALL have port ctrl_MULT, input, 1 bit: start strobe.
REQ-007 SHALL have port data_result, output, WIDTH bits: low WIDTH bits of the signed product.
REQ-008 SHALL have port data_exception, output, 1 bit: product does not fit in WIDTH signed bits.
REQ-009 SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with ctrl_MULT=1 SHALL load M=sext(A) into a WIDTH+1-bit register, Q=B, q_-1=0, acc=0, count=0, and go to RUN.
REQ-013 Each RUN cycle SHALL perform one radix-2 Booth step: (Q[0],q_-1)=01 adds M to acc; 10 adds ~M with carry-in 1; 00/11 adds 0; then arithmetic-shift {acc,Q,q_-1} right by 1; count increments.
REQ-014 RUN SHALL go to DONE after exactly WIDTH steps.
REQ-015 DONE SHALL register data_result=Q and the exception flag, assert data_resultRDY for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed: a start sampled at edge k causes data_resultRDY high during the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after the strobe (34 for WIDTH=32).
REQ-017 data_result and data_exception SHALL hold their values until the next DONE; they SHALL be unchanged while busy.
REQ-018 ctrl_MULT=1 during RUN SHALL abort the current operation and restart with the presented operands; no data_resultRDY is produced for the aborted operation.
REQ-019 ctrl_MULT=1 in DONE SHALL be accepted: DONE completes normally and the FSM goes to RUN instead of IDLE.
REQ-020 The accumulator SHALL be WIDTH+1 bits so that M = -2^(WIDTH-1) and its negation are represented without wrap.
REQ-021 The exception flag SHALL be 1 iff the upper WIDTH+1 product bits {acc[WIDTH-1:0],Q[WIDTH-1]} are not all equal.

Reset
REQ-022 reset SHALL force state IDLE, count=0, acc/Q/M/q_-1=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0 at the next rising edge.
REQ-023 reset SHALL take priority over ctrl_MULT; reset mid-RUN SHALL discard the operation with no data_resultRDY pulse.

Configuration
REQ-024 Macro MULT_EXCEPTION_EN defined SHALL build the overflow logic of REQ-021; when undefined, data_exception SHALL be constant 0 and the overflow logic SHALL be absent.

Structure
REQ-025 The FSM state encoding (IDLE/RUN/DONE), the Booth step-select encoding, and the WIDTH default SHALL live in the shared multdiv package.
REQ-026 The acc update SHALL use one sub-module, cla_adder, a WIDTH+1-bit adder with carry-in built from 8-bit carry-lookahead groups plus a top-bit ripple stage; no behavioral "+" in the datapath.

Verification
REQ-027 A=3, B=4, ctrl_MULT pulsed -> data_resultRDY high exactly 34 cycles later, data_result=12, data_exception=0.
REQ-028 A=-7, B=6 -> data_result=0xFFFFFFD6, data_exception=0.
REQ-029 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1 with MULT_EXCEPTION_EN, 0 without.
REQ-030 A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1; A=0x80000000, B=1 -> 0x80000000, exception 0.
REQ-031 Start 5*5, re-pulse ctrl_MULT with 2*3 at cycle 10 -> single data_resultRDY 34 cycles after the second strobe, result 6.
REQ-032 Start 9*9, assert reset at cycle 15 -> all outputs 0, no data_resultRDY; next 9*9 start -> 81 after 34 cycles.
